fetch_buffer: RTL and testbench

In-order instruction fetch buffer (IFB) between the fetch stage (FE) and the decode stage (ID). It accepts IFB_WIDTH-bit fetch responses and presents them to decode with a valid/pop handshake. A slot is reserved for every outstanding bus request, so a response can never overflow the buffer. On a flush it empties and silently drops the responses that are still in flight for the abandoned stream.

---
 rtl/fetch_buffer.sv | 119 +++++++++++
 tb/tb_fetch_buffer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// fetch_buffer: in-order instruction fetch buffer between fetch and decode.
//
// Every bus request reserves a slot, so a response always finds room. A
// flush empties the buffer and marks every still-outstanding response for
// silent discard; requests issued in the flush cycle belong to the new
// stream and are kept.
//
// Optional feature macro: IFB_BYPASS_EN
//   defined   - a response arriving at an empty, non-dropping buffer is
//               presented to decode in the same cycle (and not stored if
//               decode pops it immediately).
//   undefined - response-to-output latency is always one cycle.
//
// Ports:
//   s_clk_i        clock
//   s_reset_i      synchronous active-high reset
//   s_flush_i      discard buffered entries and in-flight responses
//   s_req_i        fetch issues a bus request (consumes a reservation)
//   s_req_ok_o     a reservation is available (registered state only)
//   s_rsp_val_i    fetch response valid, in request order
//   s_rsp_data_i   fetch response payload
//   s_val_o        head entry valid
//   s_data_o       head entry, zero when s_val_o is low
//   s_pop_i        decode consumes the head entry
//   s_cnt_o        number of buffered entries

package p_hardisc;
    localparam int unsigned IFB_WIDTH = 36;
endpackage

module fetch_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = p_hardisc::IFB_WIDTH
) (
    input  logic                       s_clk_i,
    input  logic                       s_reset_i,
    input  logic                       s_flush_i,
    input  logic                       s_req_i,
    output logic                       s_req_ok_o,
    input  logic                       s_rsp_val_i,
    input  logic [WIDTH-1:0]           s_rsp_data_i,
    output logic                       s_val_o,
    output logic [WIDTH-1:0]           s_data_o,
    input  logic                       s_pop_i,
    output logic [$clog2(DEPTH+1)-1:0] s_cnt_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);
    // Outstanding/drop counters need headroom: after a flush the abandoned
    // requests are still in flight while the new stream reserves again.
    localparam int unsigned OW = CW + 2;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd, wr;
    logic [CW-1:0]    cnt;
    logic [OW-1:0]    ocnt, dcnt;
    logic [OW-1:0]    live;

    logic req, push, drop, byp, pop, wr_en, rd_adv;

    assign live       = OW'(cnt) + ocnt - dcnt;
    assign s_req_ok_o = live < OW'(DEPTH);
    assign s_cnt_o    = cnt;

    always_comb begin
        req  = s_req_i && s_req_ok_o;
        drop = s_rsp_val_i && (dcnt != '0);
        push = s_rsp_val_i && (dcnt == '0) && !s_flush_i;
`ifdef IFB_BYPASS_EN
        byp  = push && (cnt == '0);
`else
        byp  = 1'b0;
`endif
        s_val_o  = (cnt != '0) || byp;
        s_data_o = s_val_o ? (byp ? s_rsp_data_i : mem[rd]) : '0;
        pop      = s_pop_i && s_val_o;
        // A bypassed entry popped in its arrival cycle is never stored.
        wr_en    = push && !(byp && pop);
        rd_adv   = pop && (cnt != '0);
    end

    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            rd   <= '0;
            wr   <= '0;
            cnt  <= '0;
            ocnt <= '0;
            dcnt <= '0;
        end else if (s_flush_i) begin
            rd   <= '0;
            wr   <= '0;
            cnt  <= '0;
            dcnt <= ocnt - OW'(s_rsp_val_i);
            ocnt <= ocnt - OW'(s_rsp_val_i) + OW'(req);
        end else begin
            if (wr_en)  wr <= wr + PW'(1);
            if (rd_adv) rd <= rd + PW'(1);
            cnt  <= cnt + CW'(wr_en) - CW'(rd_adv);
            ocnt <= ocnt + OW'(req) - OW'(s_rsp_val_i);
            if (drop) dcnt <= dcnt - OW'(1);
        end
    end

    // Payload storage is not reset; wr_en already excludes flush cycles.
    always_ff @(posedge s_clk_i) begin
        if (!s_reset_i && wr_en) mem[wr] <= s_rsp_data_i;
    end

    a_req_ok: assert property (@(posedge s_clk_i) disable iff (s_reset_i)
        s_req_i |-> s_req_ok_o);
    a_rsp_outstanding: assert property (@(posedge s_clk_i) disable iff (s_reset_i)
        s_rsp_val_i |-> (ocnt != '0));
    a_no_overflow: assert property (@(posedge s_clk_i) disable iff (s_reset_i)
        wr_en |-> (cnt != CW'(DEPTH)));
    a_drop_bound: assert property (@(posedge s_clk_i) disable iff (s_reset_i)
        dcnt <= ocnt);

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;

    localparam int DEPTH = 4;
    localparam int W     = 36;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0, req = 1'b0, rsp_val = 1'b0, pop = 1'b0;
    logic [W-1:0]  rsp_data = '0;
    logic          req_ok, val;
    logic [W-1:0]  data;
    logic [CW-1:0] cnt;

    fetch_buffer #(.DEPTH(DEPTH), .WIDTH(W)) dut (
        .s_clk_i(clk), .s_reset_i(rst), .s_flush_i(flush),
        .s_req_i(req), .s_req_ok_o(req_ok),
        .s_rsp_val_i(rsp_val), .s_rsp_data_i(rsp_data),
        .s_val_o(val), .s_data_o(data), .s_pop_i(pop), .s_cnt_o(cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: sb holds entries decode should see, in order;
    // inflight holds one flag per outstanding request (1 = will be dropped).
    logic [W-1:0] sb[$];
    bit           inflight[$];
    bit           skip = 1'b1;
    int           exp_cnt;
    bit           exp_ok, exp_val, cyc_flush;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int live_slots();
        int n = sb.size();
        foreach (inflight[i]) if (!inflight[i]) n++;
        return n;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        skip = 1'b1;
        rst = 1'b1; flush = 0; req = 0; rsp_val = 0; pop = 0;
        sb.delete();
        inflight.delete();
    endtask

    task automatic cycle(input bit r, input bit rv, input logic [W-1:0] d,
                         input bit p, input bit f);
        bit keep, rq, rvq;
        @(negedge clk);
        exp_cnt = sb.size();
        exp_ok  = live_slots() < DEPTH;
        rq      = r && exp_ok;
        rvq     = rv && (inflight.size() > 0);
        keep    = 1'b0;
        if (rvq) begin
            keep = !inflight[0];
            void'(inflight.pop_front());
        end
`ifdef IFB_BYPASS_EN
        exp_val = (exp_cnt != 0) || (keep && !f);
`else
        exp_val = (exp_cnt != 0);
`endif
        if (keep && !f) sb.push_back(d);
        if (f) foreach (inflight[i]) inflight[i] = 1'b1;
        if (rq) inflight.push_back(1'b0);
        cyc_flush = f;
        rst = 1'b0; req = rq; rsp_val = rvq; rsp_data = d; pop = p; flush = f;
        skip = 1'b0;
        #4;
        if (f) sb.delete();
    endtask

    // Monitor: compares DUT outputs with the model, consuming the
    // scoreboard whenever decode takes an entry.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!skip) begin
                check("cnt", 64'(cnt), 64'(exp_cnt));
                check("req_ok", 64'(req_ok), 64'(exp_ok));
                check("val", 64'(val), 64'(exp_val));
                if (exp_val && sb.size() > 0) begin
                    check("data", 64'(data), 64'(sb[0]));
                    if (pop && !cyc_flush) void'(sb.pop_front());
                end else begin
                    check("data_zero", 64'(data), 64'd0);
                end
            end
        end
    end

    initial begin
        logic [63:0] rnd;
        do_reset();
        // Fill reservations; the fifth request must be refused.
        repeat (5) cycle(1, 0, '0, 0, 0);
        cycle(0, 1, W'('hA), 0, 0);
        cycle(0, 1, W'('hB), 0, 0);
        cycle(0, 1, W'('hC), 0, 0);
        cycle(0, 1, W'('hD), 0, 0);
        repeat (5) cycle(0, 0, '0, 1, 0);
        // Two outstanding, flush with a new request, then X Y Z.
        repeat (2) cycle(1, 0, '0, 0, 0);
        cycle(1, 0, '0, 0, 1);
        cycle(0, 1, W'('h111), 0, 0);
        cycle(0, 1, W'('h222), 0, 0);
        cycle(0, 1, W'('h333), 0, 0);
        repeat (2) cycle(0, 0, '0, 1, 0);
        // Full buffer drained with pop held while requests refill.
        repeat (4) cycle(1, 0, '0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, W'(32'h100 + i), 0, 0);
        for (int i = 0; i < 10; i++) cycle(1, 1, W'(32'h200 + i), 1, 0);
        repeat (6) cycle(0, 1, W'('h2F0), 1, 0);
        // Flush coinciding with the only response.
        cycle(1, 0, '0, 0, 0);
        cycle(0, 1, W'('h55), 0, 1);
        repeat (2) cycle(0, 0, '0, 1, 0);
        // Response into an empty buffer with decode popping.
        cycle(1, 0, '0, 0, 0);
        cycle(0, 1, W'(32'h0000_0013), 1, 0);
        repeat (2) cycle(0, 0, '0, 1, 0);
        // Reset while entries are held and drops are pending.
        repeat (4) cycle(1, 0, '0, 0, 0);
        repeat (3) cycle(0, 1, W'('h3C), 0, 0);
        cycle(0, 0, '0, 0, 1);
        cycle(1, 0, '0, 0, 0);
        do_reset();
        cycle(1, 0, '0, 0, 0);
        cycle(0, 1, W'('h77), 0, 0);
        repeat (2) cycle(0, 0, '0, 1, 0);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                rnd = {$urandom(), $urandom()};
                cycle(($urandom_range(0, 1) == 1) && (inflight.size() < 10),
                      $urandom_range(0, 2) != 0, W'(rnd),
                      $urandom_range(0, 4) < 3, $urandom_range(0, 15) == 0);
            end
        end
        @(negedge clk);
        skip = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
